// File: rtl/gray_extract_stream.sv
// Two-stage streaming luminance extractor: gray = floor((R+G+B)/3), RGB and sideband forwarded aligned.
// Optional per-frame gray min/max statistics enabled by defining GRAY_STATS_EN.
module gray_extract_stream #(
    parameter int DW = 8
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic [DW-1:0] iR,
    input  logic [DW-1:0] iG,
    input  logic [DW-1:0] iB,
    input  logic          iSOF,
    input  logic          iEOF,
    input  logic          iVALID,
    output logic          oREADY,
    output logic [DW-1:0] oR,
    output logic [DW-1:0] oG,
    output logic [DW-1:0] oB,
    output logic [DW-1:0] oGRAY,
    output logic          oSOF,
    output logic          oEOF,
    output logic          oVALID,
    input  logic          iREADY,
    output logic [DW-1:0] oMIN,
    output logic [DW-1:0] oMAX,
    output logic          oSTAT_VALID
);

    localparam int SW = DW + 2;
    localparam int PW = 21;

    logic          adv;
    logic [SW-1:0] sum_d;
    logic [PW-1:0] prod;
    logic [DW-1:0] gray_d;

    logic          v1_q, sof1_q, eof1_q;
    logic [SW-1:0] sum1_q;
    logic [DW-1:0] r1_q, g1_q, b1_q;

    logic          v2_q, sof2_q, eof2_q;
    logic [DW-1:0] gray2_q, r2_q, g2_q, b2_q;

    logic          unused_prod_bits;

    assign adv    = ~v2_q | iREADY;
    assign oREADY = adv;

    assign sum_d  = {2'b00, iR} + {2'b00, iG} + {2'b00, iB};
    // 683/2048 is a reciprocal of 3 that floors exactly for every sum below 2048
    assign prod   = PW'(sum1_q) * 21'd683;
    assign gray_d = prod[11 +: DW];
    assign unused_prod_bits = ^{prod[PW-1:11+DW], prod[10:0]};

    // Both pipeline stages advance together; a stall freezes everything
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            v1_q    <= 1'b0;
            sof1_q  <= 1'b0;
            eof1_q  <= 1'b0;
            sum1_q  <= {SW{1'b0}};
            r1_q    <= {DW{1'b0}};
            g1_q    <= {DW{1'b0}};
            b1_q    <= {DW{1'b0}};
            v2_q    <= 1'b0;
            sof2_q  <= 1'b0;
            eof2_q  <= 1'b0;
            gray2_q <= {DW{1'b0}};
            r2_q    <= {DW{1'b0}};
            g2_q    <= {DW{1'b0}};
            b2_q    <= {DW{1'b0}};
        end else if (adv) begin
            v1_q    <= iVALID;
            sof1_q  <= iSOF;
            eof1_q  <= iEOF;
            sum1_q  <= sum_d;
            r1_q    <= iR;
            g1_q    <= iG;
            b1_q    <= iB;
            v2_q    <= v1_q;
            sof2_q  <= sof1_q;
            eof2_q  <= eof1_q;
            gray2_q <= gray_d;
            r2_q    <= r1_q;
            g2_q    <= g1_q;
            b2_q    <= b1_q;
        end
    end

    assign oVALID = v2_q;
    assign oGRAY  = gray2_q;
    assign oR     = r2_q;
    assign oG     = g2_q;
    assign oB     = b2_q;
    assign oSOF   = sof2_q;
    assign oEOF   = eof2_q;

`ifdef GRAY_STATS_EN
    logic          hs;
    logic          in_frame_q, stat_v_q;
    logic [DW-1:0] run_min_q, run_max_q, omin_q, omax_q;
    logic [DW-1:0] fmin_d, fmax_d;

    assign hs = v2_q & iREADY;

    // Running extrema including the beat currently on the output
    always_comb begin
        fmin_d = run_min_q;
        fmax_d = run_max_q;
        if (sof2_q) begin
            fmin_d = gray2_q;
            fmax_d = gray2_q;
        end else begin
            fmin_d = (gray2_q < run_min_q) ? gray2_q : run_min_q;
            fmax_d = (gray2_q > run_max_q) ? gray2_q : run_max_q;
        end
    end

    // Statistics track only handshaken beats inside an SOF-opened frame
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            in_frame_q <= 1'b0;
            stat_v_q   <= 1'b0;
            run_min_q  <= {DW{1'b0}};
            run_max_q  <= {DW{1'b0}};
            omin_q     <= {DW{1'b0}};
            omax_q     <= {DW{1'b0}};
        end else begin
            stat_v_q <= 1'b0;
            if (hs && (sof2_q || in_frame_q)) begin
                run_min_q <= fmin_d;
                run_max_q <= fmax_d;
                if (eof2_q) begin
                    omin_q     <= fmin_d;
                    omax_q     <= fmax_d;
                    stat_v_q   <= 1'b1;
                    in_frame_q <= 1'b0;
                end else begin
                    in_frame_q <= 1'b1;
                end
            end
        end
    end

    assign oMIN        = omin_q;
    assign oMAX        = omax_q;
    assign oSTAT_VALID = stat_v_q;
`else
    assign oMIN        = {DW{1'b0}};
    assign oMAX        = {DW{1'b0}};
    assign oSTAT_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_gray_extract_stream.sv
// Directed self-checking bench for gray_extract_stream (DW=8); stats checks follow GRAY_STATS_EN.
module tb_gray_extract_stream;

    logic       iCLK = 1'b0;
    logic       iRST;
    logic [7:0] iR, iG, iB;
    logic       iSOF, iEOF, iVALID, iREADY;
    logic       oREADY, oSOF, oEOF, oVALID, oSTAT_VALID;
    logic [7:0] oR, oG, oB, oGRAY, oMIN, oMAX;

    int checks = 0;
    int failures = 0;

    gray_extract_stream #(.DW(8)) dut (
        .iCLK(iCLK), .iRST(iRST), .iR(iR), .iG(iG), .iB(iB),
        .iSOF(iSOF), .iEOF(iEOF), .iVALID(iVALID), .oREADY(oREADY),
        .oR(oR), .oG(oG), .oB(oB), .oGRAY(oGRAY), .oSOF(oSOF), .oEOF(oEOF),
        .oVALID(oVALID), .iREADY(iREADY), .oMIN(oMIN), .oMAX(oMAX),
        .oSTAT_VALID(oSTAT_VALID)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        @(negedge iCLK);
    endtask

    task automatic drive(input logic [7:0] r, g, b, input logic sof, eof, valid);
        iR = r; iG = g; iB = b; iSOF = sof; iEOF = eof; iVALID = valid;
    endtask

    // Feeds one frame of gray pixels (R=G=B=gray) and watches for the statistics pulse.
    task automatic run_frame(input int n, input bit sof_first,
                             input logic [7:0] g0, g1, g2, g3,
                             input bit exp_pulse, input logic [7:0] emin, emax);
        logic [7:0] gv [4];
        int pulses = 0;
        int eof_at = -100;
        int pulse_at = -1;
        logic [7:0] pmin = 8'd0;
        logic [7:0] pmax = 8'd0;
        gv[0] = g0; gv[1] = g1; gv[2] = g2; gv[3] = g3;
        iREADY = 1'b1;
        for (int c = 0; c < n + 8; c++) begin
            if (c < n)
                drive(gv[c], gv[c], gv[c], (c == 0) && sof_first, c == n - 1, 1'b1);
            else
                drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
            tick();
            if (oVALID && oEOF) eof_at = c;
            if (oSTAT_VALID) begin
                pulses++;
                pulse_at = c;
                pmin = oMIN;
                pmax = oMAX;
            end
        end
`ifdef GRAY_STATS_EN
        chk("stat_pulse_count", pulses, exp_pulse ? 1 : 0);
        if (exp_pulse) begin
            chk("stat_pulse_timing", pulse_at, eof_at + 1);
            chk("stat_min", pmin, emin);
            chk("stat_max", pmax, emax);
        end else begin
            chk("stat_no_pulse_at", pulse_at, -1);
        end
`else
        chk("nostat_pulse_count", pulses, 0);
        chk("nostat_min", oMIN, 0);
        chk("nostat_max", oMAX, 0);
`endif
    endtask

    logic [7:0] vr [6] = '{8'd255, 8'd0, 8'd1, 8'd2, 8'd255, 8'd0};
    logic [7:0] vg [6] = '{8'd255, 8'd0, 8'd1, 8'd2, 8'd255, 8'd0};
    logic [7:0] vb [6] = '{8'd255, 8'd1, 8'd0, 8'd2, 8'd254, 8'd0};
    logic [7:0] vx [6] = '{8'd255, 8'd0, 8'd0, 8'd2, 8'd254, 8'd0};

    logic [31:0] exp_q [$];
    logic [31:0] got;
    logic [39:0] prev_out;
    bit          prev_stall;
    int          sent, recv, s, rem;
    logic [7:0]  r8, g8, b8;

    initial begin
        iRST = 1'b1;
        iREADY = 1'b1;
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge iCLK);
        tick();
        tick();
        iRST = 1'b0;

        // reset state
        chk("rst_oVALID", oVALID, 0);
        chk("rst_oREADY", oREADY, 1);
        chk("rst_oGRAY", oGRAY, 0);
        chk("rst_oSTAT_VALID", oSTAT_VALID, 0);
        chk("rst_oMIN", oMIN, 0);

        // single beat latency
        drive(8'd100, 8'd100, 8'd100, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("lat_not_yet", oVALID, 0);
        tick();
        chk("lat_oVALID", oVALID, 1);
        chk("lat_oGRAY", oGRAY, 100);
        chk("lat_oRGB", {oR, oG, oB}, {8'd100, 8'd100, 8'd100});
        tick();
        chk("lat_bubble", oVALID, 0);

        // directed arithmetic vectors
        for (int i = 0; i < 6; i++) begin
            drive(vr[i], vg[i], vb[i], 1'b0, 1'b0, 1'b1);
            tick();
            drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
            tick();
            chk("vec_valid", oVALID, 1);
            chk("vec_gray", oGRAY, vx[i]);
            chk("vec_b", oB, vb[i]);
        end

        // exhaustive sums 0..765, back to back; output lags drive by one loop step
        for (int i = 0; i <= 766; i++) begin
            if (i <= 765) begin
                s = i;
                r8 = (s > 255) ? 8'd255 : 8'(s);
                rem = s - r8;
                g8 = (rem > 255) ? 8'd255 : 8'(rem);
                b8 = 8'(rem - g8);
                drive(r8, g8, b8, 1'b0, 1'b0, 1'b1);
            end else begin
                drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
            end
            tick();
            if (i >= 1) begin
                chk("sweep_valid", oVALID, 1);
                chk("sweep_gray", oGRAY, (i - 1) / 3);
            end
        end
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // 20 continuous beats with downstream stall on cycles 5..9
        sent = 0;
        recv = 0;
        prev_stall = 1'b0;
        prev_out = 40'd0;
        for (int c = 0; c < 45; c++) begin
            iREADY = !(c >= 5 && c <= 9);
            if (sent < 20) begin
                r8 = 8'(sent * 13);
                g8 = 8'(sent * 7 + 3);
                b8 = 8'(255 - sent * 11);
                drive(r8, g8, b8, sent == 0, sent == 19, 1'b1);
            end else begin
                drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
            end
            #1;
            if (oVALID && !iREADY) chk("stall_oREADY", oREADY, 0);
            if (iREADY) chk("flow_oREADY", oREADY, 1);
            if (prev_stall) chk("stall_stable", {oR, oG, oB, oGRAY, oSOF, oEOF, oVALID, 5'd0}, prev_out);
            if (oVALID && iREADY) begin
                if (exp_q.size() == 0) begin
                    chk("stream_extra_beat", 1, 0);
                end else begin
                    got = exp_q.pop_front();
                    chk("stream_data", {oR, oG, oB, oGRAY}, got);
                end
                recv++;
            end
            prev_stall = oVALID && !iREADY;
            prev_out = {oR, oG, oB, oGRAY, oSOF, oEOF, oVALID, 5'd0};
            if (iVALID && oREADY) begin
                exp_q.push_back({r8, g8, b8, 8'((r8 + g8 + b8) / 3)});
                sent++;
            end
            tick();
        end
        iREADY = 1'b1;
        chk("stream_sent", sent, 20);
        chk("stream_recv", recv, 20);

        // frame statistics
        run_frame(4, 1'b1, 8'd50, 8'd10, 8'd200, 8'd30, 1'b1, 8'd10, 8'd200);
        chk("hold_min_after_frame", oMIN, `ifdef GRAY_STATS_EN 10 `else 0 `endif);
        run_frame(1, 1'b1, 8'd90, 8'd0, 8'd0, 8'd0, 1'b1, 8'd90, 8'd90);

        // reset with two beats in flight mid-frame
        drive(8'd250, 8'd250, 8'd250, 1'b1, 1'b0, 1'b1);
        tick();
        drive(8'd1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'd2, 8'd2, 8'd2, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        chk("mrst_oVALID", oVALID, 0);
        chk("mrst_outputs", {oR, oG, oB, oGRAY, oSOF, oEOF}, 34'd0);
        chk("mrst_stats", {oMIN, oMAX, oSTAT_VALID}, 17'd0);
        chk("mrst_oREADY", oREADY, 1);
        tick();
        chk("mrst_drained", oVALID, 0);

        // EOF without SOF after reset gives no pulse, then a clean frame
        run_frame(2, 1'b0, 8'd5, 8'd6, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        run_frame(2, 1'b1, 8'd60, 8'd70, 8'd0, 8'd0, 1'b1, 8'd60, 8'd70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
